// File: rtl/lv_bist_pkg.sv
// Shared state encoding and fail-code bit positions for the LV logic BIST sequencer.
package lv_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_OWT  = 3'd2,
    ST_INTB = 3'd3,
    ST_DONE = 3'd4
  } bist_state_e;

  localparam int FC_SCAN  = 0;
  localparam int FC_OWT   = 1;
  localparam int FC_INTB  = 2;
  localparam int FC_TMO   = 3;
  localparam int FC_ABORT = 4;
  localparam int FC_W     = 5;

  localparam int CLK_M = 48;

endpackage

// File: rtl/lv_bist_req_ch.sv
// One request/ack channel: raises req with a low gap between transactions and counts acks up to NUM.
module lv_bist_req_ch
  import lv_bist_pkg::*;
#(
  parameter  int NUM = 16,
  localparam int CW  = $clog2(NUM + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic          i_clear,
  input  logic          i_ack,
  output logic          o_req,
  output logic [CW-1:0] o_done_cnt,
  output logic          o_all_done
);

  logic          r_req;
  logic [CW-1:0] r_cnt;

  // A disabled channel drops req without counting, so an abort-cycle ack is discarded.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_req <= 1'b0;
      r_cnt <= '0;
    end else if (!i_enable) begin
      r_req <= 1'b0;
    end else if (r_req) begin
      if (i_ack) begin
        r_req <= 1'b0;
        if (r_cnt != CW'(NUM)) r_cnt <= r_cnt + 1'b1;
      end
    end else if (r_cnt != CW'(NUM)) begin
      r_req <= 1'b1;
    end
  end

  assign o_req      = r_req;
  assign o_done_cnt = r_cnt;
  assign o_all_done = (r_cnt == CW'(NUM));

endmodule

// File: rtl/lv_bist_seq.sv
// LV BIST sequencer: scan check, OWT loopback, INTB quiet window, with per-phase timeout and sticky fail code.
// states: IDLE=waiting | SCAN=scan-reg checks | OWT=loopback txns | INTB=quiet window | DONE=result held
module lv_bist_seq
  import lv_bist_pkg::*;
#(
  parameter int SCAN_REG_NUM  = 16,
  parameter int OWT_TX_NUM    = 4,
  parameter int OWT_OK_MIN    = 3,
  parameter int PHASE_TMO_CYC = 96000,
  parameter int INTB_WIN_CYC  = 4800
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_bist_start,
  input  logic       i_bist_abort,
  output logic       o_scan_req,
  input  logic       i_scan_ack,
  input  logic       i_scan_err,
  output logic       o_owt_tx_req,
  input  logic       i_owt_rx_ack,
  input  logic       i_owt_rx_status,
  input  logic       i_hv_intb0_pulse,
  input  logic       i_hv_intb1_pulse,
  output logic       o_bist_busy,
  output logic       o_bist_done,
  output logic       o_bist_pass,
  output logic [4:0] o_bist_fail_code,
  output logic [2:0] o_bist_state
);

  localparam int SW = $clog2(SCAN_REG_NUM + 1);
  localparam int OW = $clog2(OWT_TX_NUM + 1);
  localparam int TW = $clog2(PHASE_TMO_CYC);
  localparam int WW = $clog2(INTB_WIN_CYC);

  bist_state_e     r_state, w_next;
  logic [FC_W-1:0] r_fail, w_fail_set;
  logic [TW-1:0]   r_tmo_cnt;
  logic [WW-1:0]   r_win_cnt;
  logic [OW-1:0]   r_owt_ok, w_owt_ok_nxt;
  logic [SW-1:0]   w_scan_cnt;
  logic [OW-1:0]   w_owt_cnt;
  logic w_scan_all, w_owt_all, w_scan_en, w_owt_en;
  logic w_busy, w_start, w_abort, w_scan_ack, w_owt_ack, w_scan_last, w_owt_last;
  logic w_tmo_hit, w_scan_tmo, w_owt_tmo, w_win_end;

  assign w_busy      = (r_state == ST_SCAN) || (r_state == ST_OWT) || (r_state == ST_INTB);
  assign w_start     = i_bist_start && !w_busy;
  assign w_abort     = i_bist_abort && w_busy;
  assign w_scan_ack  = o_scan_req && i_scan_ack;
  assign w_owt_ack   = o_owt_tx_req && i_owt_rx_ack;
  assign w_scan_last = w_scan_ack && (w_scan_cnt == SW'(SCAN_REG_NUM - 1));
  assign w_owt_last  = w_owt_ack && (w_owt_cnt == OW'(OWT_TX_NUM - 1));
  assign w_tmo_hit   = (r_tmo_cnt == '0);
  // A completing ack in the timeout cycle wins, so no timeout is flagged.
  assign w_scan_tmo  = (r_state == ST_SCAN) && w_tmo_hit && !w_scan_last;
  assign w_owt_tmo   = (r_state == ST_OWT) && w_tmo_hit && !w_owt_last;
  assign w_win_end   = (r_win_cnt == '0);
  assign w_scan_en   = (r_state == ST_SCAN) && !w_abort && !w_scan_tmo && !w_scan_all;
  assign w_owt_en    = (r_state == ST_OWT) && !w_abort && !w_owt_tmo && !w_owt_all;
  assign w_owt_ok_nxt = (w_owt_ack && !i_owt_rx_status && (r_owt_ok != OW'(OWT_TX_NUM)))
                        ? r_owt_ok + 1'b1 : r_owt_ok;

  lv_bist_req_ch #(.NUM(SCAN_REG_NUM)) u_scan_ch (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (w_scan_en),
    .i_clear    (w_start),
    .i_ack      (i_scan_ack),
    .o_req      (o_scan_req),
    .o_done_cnt (w_scan_cnt),
    .o_all_done (w_scan_all)
  );

  lv_bist_req_ch #(.NUM(OWT_TX_NUM)) u_owt_ch (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (w_owt_en),
    .i_clear    (w_start),
    .i_ack      (i_owt_rx_ack),
    .o_req      (o_owt_tx_req),
    .o_done_cnt (w_owt_cnt),
    .o_all_done (w_owt_all)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_SCAN;
      ST_SCAN: begin
        if (w_abort) w_next = ST_DONE;
        else if (w_scan_last || w_scan_tmo) w_next = ST_OWT;
      end
      ST_OWT: begin
        if (w_abort) w_next = ST_DONE;
        else if (w_owt_last || w_owt_tmo) w_next = ST_INTB;
      end
      ST_INTB: if (w_abort || w_win_end) w_next = ST_DONE;
      ST_DONE: if (w_start) w_next = ST_SCAN;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_bist_busy      = w_busy;
    o_bist_done      = (r_state == ST_DONE);
    o_bist_pass      = (r_state == ST_DONE) && (r_fail == '0);
    o_bist_fail_code = r_fail;
    o_bist_state     = r_state;
  end

  always_comb begin
    w_fail_set = '0;
    if (w_abort) begin
      w_fail_set[FC_ABORT] = 1'b1;
    end else begin
      case (r_state)
        ST_SCAN: begin
          if (w_scan_ack && i_scan_err) w_fail_set[FC_SCAN] = 1'b1;
          if (w_scan_tmo) begin
            w_fail_set[FC_SCAN] = 1'b1;
            w_fail_set[FC_TMO]  = 1'b1;
          end
        end
        ST_OWT: begin
          if (w_owt_last && (w_owt_ok_nxt < OW'(OWT_OK_MIN))) w_fail_set[FC_OWT] = 1'b1;
          if (w_owt_tmo) begin
            w_fail_set[FC_OWT] = 1'b1;
            w_fail_set[FC_TMO] = 1'b1;
          end
        end
        ST_INTB: if (i_hv_intb0_pulse || i_hv_intb1_pulse) w_fail_set[FC_INTB] = 1'b1;
        default: ;
      endcase
    end
  end

  // Timeout and window are down-counters reloaded on every phase change; terminal count is zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fail    <= '0;
      r_owt_ok  <= '0;
      r_tmo_cnt <= '0;
      r_win_cnt <= '0;
    end else if (w_start) begin
      r_fail    <= '0;
      r_owt_ok  <= '0;
      r_tmo_cnt <= TW'(PHASE_TMO_CYC - 1);
      r_win_cnt <= '0;
    end else begin
      r_fail <= r_fail | w_fail_set;
      if (!w_abort) r_owt_ok <= w_owt_ok_nxt;
      if (w_next != r_state)
        r_tmo_cnt <= TW'(PHASE_TMO_CYC - 1);
      else if ((r_state == ST_SCAN || r_state == ST_OWT) && !w_tmo_hit)
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
      if (w_next == ST_INTB && r_state != ST_INTB)
        r_win_cnt <= WW'(INTB_WIN_CYC - 1);
      else if (r_state == ST_INTB && !w_win_end)
        r_win_cnt <= r_win_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_lv_bist_seq.sv
// Bench for lv_bist_seq: per-run expected results queued at start and checked when DONE rises.
`timescale 1ns/1ps
module tb_lv_bist_seq;

  localparam int SCAN_N = 16;
  localparam int OWT_N  = 4;
  localparam int OK_MIN = 3;
  localparam int TMO    = 600;
  localparam int WIN    = 100;

  typedef struct {
    logic [4:0] fc;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, intb0, intb1;
  logic resp_scan_ack = 1'b0, resp_scan_err = 1'b0, resp_owt_ack = 1'b0, resp_owt_st = 1'b0;
  logic frc_scan_ack, frc_scan_err, frc_owt_ack;
  logic o_scan_req, o_owt_tx_req, o_bist_busy, o_bist_done, o_bist_pass;
  logic [4:0] o_bist_fail_code;
  logic [2:0] o_bist_state;

  lv_bist_seq #(
    .SCAN_REG_NUM(SCAN_N), .OWT_TX_NUM(OWT_N), .OWT_OK_MIN(OK_MIN),
    .PHASE_TMO_CYC(TMO), .INTB_WIN_CYC(WIN)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_bist_start     (start),
    .i_bist_abort     (abort),
    .o_scan_req       (o_scan_req),
    .i_scan_ack       (resp_scan_ack | frc_scan_ack),
    .i_scan_err       (resp_scan_err | frc_scan_err),
    .o_owt_tx_req     (o_owt_tx_req),
    .i_owt_rx_ack     (resp_owt_ack | frc_owt_ack),
    .i_owt_rx_status  (resp_owt_st),
    .i_hv_intb0_pulse (intb0),
    .i_hv_intb1_pulse (intb1),
    .o_bist_busy      (o_bist_busy),
    .o_bist_done      (o_bist_done),
    .o_bist_pass      (o_bist_pass),
    .o_bist_fail_code (o_bist_fail_code),
    .o_bist_state     (o_bist_state)
  );

  int n_chk = 0;
  int n_pass = 0;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Responder: scan acks 3 cycles into each request, OWT acks 2 cycles in.
  int scan_wait = 0, scan_idx = 0, owt_wait = 0, owt_idx = 0;
  int scan_err_idx = -1;
  bit owt_ack_en = 1'b1;
  logic [OWT_N-1:0] owt_status = '0;

  always @(negedge clk) begin
    resp_scan_ack = 1'b0;
    resp_scan_err = 1'b0;
    resp_owt_ack  = 1'b0;
    resp_owt_st   = 1'b0;
    if (o_bist_state !== 3'd1) begin
      scan_idx = 0; scan_wait = 0;
    end else if (o_scan_req === 1'b1) begin
      scan_wait++;
      if (scan_wait == 3) begin
        resp_scan_ack = 1'b1;
        resp_scan_err = (scan_idx == scan_err_idx);
        scan_idx++;
        scan_wait = 0;
      end
    end else scan_wait = 0;
    if (o_bist_state !== 3'd2) begin
      owt_idx = 0; owt_wait = 0;
    end else if (o_owt_tx_req === 1'b1 && owt_ack_en) begin
      owt_wait++;
      if (owt_wait == 2) begin
        resp_owt_ack = 1'b1;
        resp_owt_st  = (owt_idx < OWT_N) ? owt_status[owt_idx] : 1'b0;
        owt_idx++;
        owt_wait = 0;
      end
    end else owt_wait = 0;
  end

  // Monitor: req must drop after a sampled ack; count request rises; pop scoreboard on DONE.
  bit mon_en = 1'b0;
  logic hs_scan = 1'b0, hs_owt = 1'b0, prev_scan = 1'b0, prev_owt = 1'b0, prev_done = 1'b0;
  int scan_rises = 0, owt_rises = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (hs_scan) chk("scan_req_drop", o_scan_req, 0);
      if (hs_owt)  chk("owt_req_drop", o_owt_tx_req, 0);
      if (o_scan_req && !prev_scan) scan_rises++;
      if (o_owt_tx_req && !prev_owt) owt_rises++;
      if (o_bist_done && !prev_done) begin
        chk("sb_pending", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          chk("sb_fail_code", o_bist_fail_code, mon_e.fc);
          chk("sb_pass", o_bist_pass, mon_e.pass);
        end
      end
      hs_scan   = o_scan_req & (resp_scan_ack | frc_scan_ack);
      hs_owt    = o_owt_tx_req & (resp_owt_ack | frc_owt_ack);
      prev_scan = o_scan_req;
      prev_owt  = o_owt_tx_req;
      prev_done = o_bist_done;
    end
  end

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (o_bist_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, o_bist_state, s);
  endtask

  task automatic start_run(input logic [4:0] fc, input logic pass);
    exp_t e;
    e.fc = fc;
    e.pass = pass;
    sb_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, o_bist_state, 0);
    chk({tag, "_busy"}, o_bist_busy, 0);
    chk({tag, "_done"}, o_bist_done, 0);
    chk({tag, "_pass"}, o_bist_pass, 0);
    chk({tag, "_fc"}, o_bist_fail_code, 0);
    chk({tag, "_scan_req"}, o_scan_req, 0);
    chk({tag, "_owt_req"}, o_owt_tx_req, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int s0, o0, n;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; intb0 = 1'b0; intb1 = 1'b0;
    frc_scan_ack = 1'b0; frc_scan_err = 1'b0; frc_owt_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Nominal run
    s0 = scan_rises; o0 = owt_rises;
    start_run(5'b00000, 1'b1);
    chk("t1_state_scan", o_bist_state, 1);
    chk("t1_req_low_on_entry", o_scan_req, 0);
    @(negedge clk);
    chk("t1_req_rise", o_scan_req, 1);
    chk("t1_busy", o_bist_busy, 1);
    wait_state(3'd4, 1000, "t1_done");
    chk("t1_scan_reqs", scan_rises - s0, SCAN_N);
    chk("t1_owt_reqs", owt_rises - o0, OWT_N);
    chk("t1_done_reqs_low", {o_scan_req, o_owt_tx_req}, 0);

    // Scan error on 5th ack, OWT ok count short
    scan_err_idx = 4;
    owt_status = 4'b0110;
    start_run(5'b00011, 1'b0);
    chk("t2_restart", o_bist_state, 1);
    wait_state(3'd4, 1000, "t2_done");
    chk("t2_fc", o_bist_fail_code, 5'b00011);

    // OWT timeout
    scan_err_idx = -1;
    owt_status = '0;
    owt_ack_en = 1'b0;
    start_run(5'b01010, 1'b0);
    wait_state(3'd2, 500, "t3_owt_entry");
    n = 0;
    while (o_bist_state === 3'd2 && n < TMO + 10) begin
      @(negedge clk);
      n++;
    end
    chk("t3_tmo_cycles", n, TMO);
    chk("t3_intb_state", o_bist_state, 3);
    chk("t3_owt_req_drop", o_owt_tx_req, 0);
    chk("t3_fc_tmo", o_bist_fail_code, 5'b01010);
    owt_ack_en = 1'b1;
    wait_state(3'd4, WIN + 20, "t3_done");

    // INTB pulse on last window cycle, then one after DONE
    start_run(5'b00100, 1'b0);
    wait_state(3'd3, 1000, "t4_intb_entry");
    repeat (WIN - 1) @(negedge clk);
    chk("t4_state_last_cycle", o_bist_state, 3);
    chk("t4_fc_before", o_bist_fail_code, 0);
    intb1 = 1'b1;
    @(negedge clk);
    intb1 = 1'b0;
    chk("t4_state_done", o_bist_state, 4);
    chk("t4_fc_intb", o_bist_fail_code, 5'b00100);
    intb0 = 1'b1;
    @(negedge clk);
    intb0 = 1'b0;
    chk("t4_fc_after_done", o_bist_fail_code, 5'b00100);

    // Abort + start + ack in the same OWT cycle
    owt_ack_en = 1'b0;
    start_run(5'b10000, 1'b0);
    wait_state(3'd2, 500, "t5_owt_entry");
    n = 0;
    while (o_owt_tx_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t5_owt_req_hi", o_owt_tx_req, 1);
    abort = 1'b1; start = 1'b1; frc_owt_ack = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0; frc_owt_ack = 1'b0;
    chk("t5_state_done", o_bist_state, 4);
    chk("t5_fc_abort", o_bist_fail_code, 5'b10000);
    chk("t5_owt_req_low", o_owt_tx_req, 0);
    @(negedge clk);
    chk("t5_start_ignored", o_bist_state, 4);
    owt_ack_en = 1'b1;

    // Reset mid-scan with req high
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (o_scan_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t6_scan_req_hi", o_scan_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("t6_reset");

    // Stray ack with err while req low must not count
    s0 = scan_rises;
    start_run(5'b00000, 1'b1);
    chk("t6_req_low", o_scan_req, 0);
    frc_scan_ack = 1'b1; frc_scan_err = 1'b1;
    @(negedge clk);
    frc_scan_ack = 1'b0; frc_scan_err = 1'b0;
    chk("t6_req_rise", o_scan_req, 1);
    wait_state(3'd4, 1000, "t6_done");
    chk("t6_scan_reqs", scan_rises - s0, SCAN_N);

    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
